// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for the DIP switches.
// Define SWITCH_DEBOUNCE_BYPASS_EN to drop the counters for fast simulation.
module switch_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic             int_osc,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] digit,
    output logic             changed
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] digit_q, digit_d;
    logic             changed_q, changed_d;

`ifdef SWITCH_DEBOUNCE_BYPASS_EN

    always_comb begin
        sync1_d   = s;
        sync2_d   = sync1_q;
        digit_d   = sync2_q;
        changed_d = (sync2_q != digit_q);
    end

    always_ff @(posedge int_osc or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            digit_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            digit_q   <= digit_d;
            changed_q <= changed_d;
        end
    end

`else

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] upd;

    // A full count forces the update and clears the counter, so it never wraps.
    always_comb begin
        sync1_d = s;
        sync2_d = sync1_q;
        digit_d = digit_q;
        upd     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == digit_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                digit_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                upd[i]     = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        changed_d = |upd;
    end

    always_ff @(posedge int_osc or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            digit_q   <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            digit_q   <= digit_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`endif

    assign digit   = digit_q;
    assign changed = changed_q;

endmodule
